mem_stage_access_unit: RTL
==========================

Name: mem_stage_access_unit

Overview:
- MEM-stage producer for the MEM/WB pipeline registers in the 5-stage MIPS core.
- Takes the load/store request latched in EX/MEM and runs a valid/ready request plus valid response handshake to data memory.
- Formats load data into mem_memoryData and stalls the pipeline until the access completes.
- Handles byte, halfword and word accesses (little-endian), misalignment detection and a response watchdog.

Parameters:
- RSP_TIMEOUT, 255, max cycles waiting in RESP before bus error; 0 disables the watchdog.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- mem_valid  in  1  EX/MEM holds a live instruction
- mem_readEnable  in  1  load instruction
- mem_writeEnable  in  1  store instruction
- mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_signExtend  in  1  sign-extend sub-word loads (else zero-extend)
- mem_address  in  32  effective address (ALU output)
- mem_storeData  in  32  store source register value
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_write  out  1  1 = store, 0 = load
- dmem_req_addr  out  32  word-aligned address {addr[31:2],2'b00}
- dmem_req_wdata  out  32  lane-replicated store data
- dmem_req_byteEnable  out  4  lane strobes
- dmem_rsp_valid  in  1  load data valid
- dmem_rsp_rdata  in  32  raw load word
- mem_memoryData  out  32  formatted load result, toward the WB register input
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB
- mem_done  out  1  one-cycle completion pulse
- mem_misaligned  out  1  misaligned access flag, combinational
- mem_busError  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset: all registered outputs are 0 and the state is IDLE. A reset mid-transaction abandons the access; dmem_req_valid is low from the next cycle.
- Access = mem_valid & (mem_readEnable | mem_writeEnable). If both enables are set, the access is a store.
- Misaligned = (half & addr[0]) | (word & addr[1:0] != 0).
  - mem_misaligned is asserted combinationally in IDLE.
  - No request is issued, mem_stall stays 0 and mem_memoryData is forced to 0 at the next edge.
- Byte enables and store data:
  - byte: 0001 shifted left by addr[1:0]; wdata = {4{storeData[7:0]}}.
  - half: 0011 if addr[1]=0, else 1100; wdata = {2{storeData[15:0]}}.
  - word: 1111; wdata = storeData.
  - A load drives its byte enables with the same encoding.
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE: on an aligned access, latch write, addr, wdata, byteEnable, size, sign and addr[1:0], then go to REQ. mem_stall = 1 combinationally in this same cycle.
  - REQ: dmem_req_valid = 1; all req fields are held stable until accepted.
    - Handshake occurs when valid & ready.
    - Store: go to DONE.
    - Load: go to RESP and clear the watchdog counter.
    - dmem_req_valid never drops before the handshake.
  - RESP: dmem_req_valid = 0.
    - On dmem_rsp_valid: shift rdata right by 8*addr[1:0], then extend.
      - byte: bits [7:0], extended by sign ? bit7 : 0.
      - half: bits [15:0], extended by sign ? bit15 : 0.
      - word: unchanged.
    - Register the result into mem_memoryData and go to DONE.
    - If RSP_TIMEOUT != 0 and the counter reaches RSP_TIMEOUT with no response: pulse mem_busError, set mem_memoryData = 0, go to DONE.
    - rsp_valid in the same cycle as expiry wins; no error is flagged.
  - DONE: mem_stall = 0 and mem_done = 1 for this one cycle, so MEM/WB captures the result at this edge. Then go to IDLE unconditionally; the instruction is not re-issued.
- mem_stall = 1 while (IDLE & aligned access) or in REQ or RESP; 0 otherwise.
- mem_memoryData holds its value between accesses.
- Stores leave mem_memoryData unchanged.
- dmem_rsp_valid outside RESP is ignored.
- Minimum latency, store: 3 cycles (IDLE, REQ with ready=1, DONE).
- Minimum latency, load: 4 cycles (IDLE, REQ, RESP with rsp_valid=1, DONE).

Test Plan:
- Word load at 0x100, ready=1 immediately, rsp_valid next cycle with 0xDEADBEEF -> req_addr=0x100, byteEnable=1111, mem_memoryData=0xDEADBEEF, mem_done pulses in cycle 4, mem_stall high for exactly 3 cycles.
- Signed byte load at 0x103, rdata=0x80112233 -> mem_memoryData=0xFFFFFF80; repeat with mem_signExtend=0 -> 0x00000080.
- Half store at 0x202, storeData=0x0000ABCD, ready held low 5 cycles -> req fields stable throughout, req_addr=0x200, byteEnable=1100, wdata=0xABCDABCD, single handshake, mem_done after acceptance.
- Word load at 0x105 -> mem_misaligned=1, no dmem_req_valid, mem_stall=0, mem_memoryData=0.
- RSP_TIMEOUT=4, load accepted, no response -> mem_busError pulses once after 4 RESP cycles, mem_memoryData=0, state returns to IDLE.
- Reset asserted in RESP, then rsp_valid arrives -> outputs 0, rsp ignored, a new access proceeds normally.

Source files
------------

// File: rtl/mem_stage_access_unit.sv
// MEM-stage data memory access unit: issues load/store requests over a
// valid/ready request channel, formats returned load data for MEM/WB and
// stalls the pipeline until the access finishes or the watchdog expires.
module mem_stage_access_unit #(
   parameter int unsigned RSP_TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic        mem_readEnable,
   input  logic        mem_writeEnable,
   input  logic [1:0]  mem_size,
   input  logic        mem_signExtend,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_storeData,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic        dmem_req_write,
   output logic [31:0] dmem_req_addr,
   output logic [31:0] dmem_req_wdata,
   output logic [3:0]  dmem_req_byteEnable,
   input  logic        dmem_rsp_valid,
   input  logic [31:0] dmem_rsp_rdata,
   output logic [31:0] mem_memoryData,
   output logic        mem_stall,
   output logic        mem_done,
   output logic        mem_misaligned,
   output logic        mem_busError
);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   state_t      state_q;
   logic        write_q;
   logic [29:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic [1:0]  size_q;
   logic        sign_q;
   logic [1:0]  lane_q;
   logic [31:0] data_q;
   logic        busError_q;
   logic [31:0] cnt_q;

   logic        access;
   logic        misal;
   logic [3:0]  be_d;
   logic [31:0] wdata_d;
   logic [31:0] shifted;
   logic [31:0] load_d;
   logic        wd_expire;

   // Decode the incoming access: alignment, lane strobes, replicated store data.
   always_comb begin
      access  = mem_valid & (mem_readEnable | mem_writeEnable);
      misal   = ((mem_size == 2'b01) & mem_address[0]) |
                (mem_size[1] & (mem_address[1:0] != 2'b00));
      be_d    = 4'b1111;
      wdata_d = mem_storeData;
      case (mem_size)
         2'b00: begin
            be_d    = 4'b0001 << mem_address[1:0];
            wdata_d = {4{mem_storeData[7:0]}};
         end
         2'b01: begin
            be_d    = mem_address[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{mem_storeData[15:0]}};
         end
         default: begin
            be_d    = 4'b1111;
            wdata_d = mem_storeData;
         end
      endcase
   end

   // Align the returned word to the addressed lane and extend sub-word loads.
   always_comb begin
      shifted = dmem_rsp_rdata >> {lane_q, 3'b000};
      case (size_q)
         2'b00:   load_d = {{24{sign_q & shifted[7]}}, shifted[7:0]};
         2'b01:   load_d = {{16{sign_q & shifted[15]}}, shifted[15:0]};
         default: load_d = dmem_rsp_rdata;
      endcase
      wd_expire = (RSP_TIMEOUT != 0) && ((cnt_q + 32'd1) == RSP_TIMEOUT);
   end

   // Access sequencer: latch request, handshake, collect response, report.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         write_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         size_q     <= '0;
         sign_q     <= 1'b0;
         lane_q     <= '0;
         data_q     <= '0;
         busError_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         busError_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (access) begin
                  if (misal) begin
                     data_q <= '0;
                  end else begin
                     write_q <= mem_writeEnable;
                     addr_q  <= mem_address[31:2];
                     wdata_q <= wdata_d;
                     be_q    <= be_d;
                     size_q  <= mem_size;
                     sign_q  <= mem_signExtend;
                     lane_q  <= mem_address[1:0];
                     state_q <= REQ;
                  end
               end
            end
            REQ: begin
               if (dmem_req_ready) begin
                  if (write_q) begin
                     state_q <= DONE;
                  end else begin
                     state_q <= RESP;
                     cnt_q   <= '0;
                  end
               end
            end
            RESP: begin
               // A response arriving on the expiry cycle takes priority.
               if (dmem_rsp_valid) begin
                  data_q  <= load_d;
                  state_q <= DONE;
               end else if (wd_expire) begin
                  busError_q <= 1'b1;
                  data_q     <= '0;
                  state_q    <= DONE;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dmem_req_valid      = (state_q == REQ);
   assign dmem_req_write      = write_q;
   assign dmem_req_addr       = {addr_q, 2'b00};
   assign dmem_req_wdata      = wdata_q;
   assign dmem_req_byteEnable = be_q;
   assign mem_memoryData      = data_q;
   assign mem_done            = (state_q == DONE);
   assign mem_busError        = busError_q;
   assign mem_misaligned      = (state_q == IDLE) & access & misal;
   assign mem_stall           = ((state_q == IDLE) & access & ~misal) |
                                (state_q == REQ) | (state_q == RESP);

endmodule
